xge_rst_seq: RTL and testbench

XGE_RST_SEQ -- requirements
Module: xge_rst_seq

---
 rtl/xge_pkg.sv | 32 +++
 rtl/xge_bit_sync.sv | 24 ++
 rtl/xge_rst_seq.sv | 117 +++++++++++
 tb/tb_xge_rst_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/xge_pkg.sv
// Shared types and defaults for the 10GbE reset sequencer.
// Output words are ordered {pcs_rst, mac_rst, app_rst, rst_done}.
package xge_pkg;

   localparam int LOCK_STABLE_DEF = 1024;
   localparam int STAGE_GAP_DEF   = 64;
   localparam int WDOG_DEF        = 1562500;
   localparam int RCNT_W          = 8;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      WAIT_BLK,
      MAC_REL,
      RUN
   } state_t;

   localparam logic [3:0] OUT_WAIT_LOCK = 4'b1110;
   localparam logic [3:0] OUT_WAIT_BLK  = 4'b0110;
   localparam logic [3:0] OUT_MAC_REL   = 4'b0010;
   localparam logic [3:0] OUT_RUN       = 4'b0001;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [RCNT_W-1:0] sat_inc(input logic [RCNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/xge_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on rst.
module xge_bit_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic meta;
   (* ASYNC_REG = "TRUE" *) logic sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= d;
         sync <= meta;
      end
   end

   assign q = sync;

endmodule

// File: rtl/xge_rst_seq.sv
// 10GbE reset sequencer: releases PCS, then MAC, then application resets in order.
// Optional block-lock watchdog in WAIT_BLK is enabled by defining XGE_RST_WDOG_EN.
module xge_rst_seq
   import xge_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_DEF,
   parameter int STAGE_GAP_CYCLES   = STAGE_GAP_DEF,
   parameter int WDOG_CYCLES        = WDOG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_lock,
   input  logic              blk_lock,
   output logic              pcs_rst,
   output logic              mac_rst,
   output logic              app_rst,
   output logic              rst_done,
   output logic [RCNT_W-1:0] restart_cnt
);

   localparam int CW = $clog2(max3(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, WDOG_CYCLES)) + 1;
   localparam logic [CW-1:0] LOCK_N   = CW'(LOCK_STABLE_CYCLES);
   localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP_CYCLES - 1);

   state_t        state;
   logic [3:0]    outs;
   logic [CW-1:0] cnt;
   logic          lock_s;

   xge_bit_sync u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_lock),
      .q   (lock_s)
   );

`ifdef XGE_RST_WDOG_EN
   localparam logic [CW-1:0] WD_LAST = CW'(WDOG_CYCLES - 1);
   logic [CW-1:0] wd_cnt;

   // Held at zero outside WAIT_BLK, so it restarts on every entry.
   always_ff @(posedge clk) begin
      if (rst || state != WAIT_BLK) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + 1'b1;
   end
`endif

   // Lock loss outranks every other cause, so a coincident restart counts once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= WAIT_LOCK;
         outs        <= OUT_WAIT_LOCK;
         cnt         <= '0;
         restart_cnt <= '0;
      end else if (!lock_s && state != WAIT_LOCK) begin
         state       <= WAIT_LOCK;
         outs        <= OUT_WAIT_LOCK;
         cnt         <= '0;
         restart_cnt <= sat_inc(restart_cnt);
      end else begin
         case (state)
            WAIT_LOCK: begin
               if (!lock_s) cnt <= '0;
               else if (cnt == LOCK_N) begin
                  state <= WAIT_BLK;
                  outs  <= OUT_WAIT_BLK;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            end
            WAIT_BLK: begin
`ifdef XGE_RST_WDOG_EN
               if (wd_cnt == WD_LAST) begin
                  state       <= WAIT_LOCK;
                  outs        <= OUT_WAIT_LOCK;
                  cnt         <= '0;
                  restart_cnt <= sat_inc(restart_cnt);
               end else
`endif
               if (!blk_lock) cnt <= '0;
               else if (cnt == GAP_LAST) begin
                  state <= MAC_REL;
                  outs  <= OUT_MAC_REL;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            end
            MAC_REL: begin
               if (!blk_lock) begin
                  state       <= WAIT_BLK;
                  outs        <= OUT_WAIT_BLK;
                  cnt         <= '0;
                  restart_cnt <= sat_inc(restart_cnt);
               end else if (cnt == GAP_LAST) begin
                  state <= RUN;
                  outs  <= OUT_RUN;
                  cnt   <= '0;
               end else cnt <= cnt + 1'b1;
            end
            RUN: begin
               if (!blk_lock) begin
                  state       <= WAIT_BLK;
                  outs        <= OUT_WAIT_BLK;
                  cnt         <= '0;
                  restart_cnt <= sat_inc(restart_cnt);
               end
            end
            default: begin
               state <= WAIT_LOCK;
               outs  <= OUT_WAIT_LOCK;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign {pcs_rst, mac_rst, app_rst, rst_done} = outs;

endmodule

// File: tb/tb_xge_rst_seq.sv
// Scoreboard bench for xge_rst_seq: timed expectations are queued with the stimulus
// and compared at the negedge of the cycle they fall due.
module tb_xge_rst_seq;

   localparam int LOCK = 8;
   localparam int GAP  = 4;
   localparam int WDOG = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;
   logic       blk_lock = 1'b0;
   logic       pcs_rst, mac_rst, app_rst, rst_done;
   logic [7:0] restart_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          at;
      string       tag;
      logic [11:0] want;
   } exp_t;

   exp_t sb[$];

   xge_rst_seq #(
      .LOCK_STABLE_CYCLES (LOCK),
      .STAGE_GAP_CYCLES   (GAP),
      .WDOG_CYCLES        (WDOG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pll_lock    (pll_lock),
      .blk_lock    (blk_lock),
      .pcs_rst     (pcs_rst),
      .mac_rst     (mac_rst),
      .app_rst     (app_rst),
      .rst_done    (rst_done),
      .restart_cnt (restart_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] obs();
      return {pcs_rst, mac_rst, app_rst, rst_done, restart_cnt};
   endfunction

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc %0d got %h want %h", tag, cyc, got, want);
      end
   endtask

   // Sorted insert so the monitor can always serve the head first.
   task automatic push(input int at, input string tag, input bit p, input bit m,
                       input bit a, input bit d, input int rc);
      exp_t e;
      int   i;
      e.at   = at;
      e.tag  = tag;
      e.want = {p, m, a, d, 8'(rc)};
      i = sb.size();
      while (i > 0 && sb[i-1].at > at) i--;
      sb.insert(i, e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.at == cyc) chk(e.tag, obs(), e.want);
         else             chk({e.tag, "_late"}, 12'(cyc), 12'(e.at));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Nominal release timing, e0 = cycle index of the first edge that samples pll_lock = 1.
   task automatic seq_exp(input int e0, input int rc, input string s);
      push(e0 + 9,  {s, "_pcs_hi"}, 1, 1, 1, 0, rc);
      push(e0 + 10, {s, "_pcs_lo"}, 0, 1, 1, 0, rc);
      push(e0 + 13, {s, "_mac_hi"}, 0, 1, 1, 0, rc);
      push(e0 + 14, {s, "_mac_lo"}, 0, 0, 1, 0, rc);
      push(e0 + 17, {s, "_app_hi"}, 0, 0, 1, 0, rc);
      push(e0 + 18, {s, "_run"},    0, 0, 0, 1, rc);
   endtask

   initial begin
      int c;
      int e0;
      int n;

      tick(1);
      push(cyc + 1, "reset", 1, 1, 1, 0, 0);
      tick(3);

      // nominal release
      rst = 1'b0; pll_lock = 1'b1; blk_lock = 1'b1;
      seq_exp(cyc + 1, 0, "s1");
      tick(22);

      // PLL lock lost in RUN, then full sequence again
      c = cyc;
      pll_lock = 1'b0;
      push(c + 2, "s3_still_run", 0, 0, 0, 1, 0);
      push(c + 3, "s3_drop",      1, 1, 1, 0, 1);
      tick(3);
      pll_lock = 1'b1;
      seq_exp(c + 4, 1, "s3");
      tick(22);

      // block lock lost in RUN for two cycles
      c = cyc;
      blk_lock = 1'b0;
      push(c + 1, "s4_drop", 0, 1, 1, 0, 2);
      tick(2);
      blk_lock = 1'b1;
      push(c + 5,  "s4_wait_blk", 0, 1, 1, 0, 2);
      push(c + 6,  "s4_mac_lo",   0, 0, 1, 0, 2);
      push(c + 9,  "s4_app_hi",   0, 0, 1, 0, 2);
      push(c + 10, "s4_run",      0, 0, 0, 1, 2);
      tick(12);

      // reset asserted mid-MAC_REL
      c = cyc;
      blk_lock = 1'b0;
      tick(2);
      blk_lock = 1'b1;
      push(c + 6, "s6_mac_rel", 0, 0, 1, 0, 3);
      tick(4);
      rst = 1'b1;
      push(c + 7, "s6_rst", 1, 1, 1, 0, 0);
      tick(3);

      // one-cycle lock glitch during qualification
      rst = 1'b0; pll_lock = 1'b1; blk_lock = 1'b1;
      e0 = cyc + 1;
      push(e0 + 10, "s2_hold",   1, 1, 1, 0, 0);
      push(e0 + 16, "s2_pcs_hi", 1, 1, 1, 0, 0);
      push(e0 + 17, "s2_pcs_lo", 0, 1, 1, 0, 0);
      tick(6);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(14);

      // block lock never comes up
      rst = 1'b1;
      tick(2);
      rst = 1'b0; blk_lock = 1'b0;
      e0 = cyc + 1;
      push(e0 + 10, "s5_wait_blk", 0, 1, 1, 0, 0);
      push(e0 + 41, "s5_pre",      0, 1, 1, 0, 0);
`ifdef XGE_RST_WDOG_EN
      push(e0 + 42, "s5_wdog",     1, 1, 1, 0, 1);
`else
      push(e0 + 42, "s5_no_wdog",  0, 1, 1, 0, 0);
      push(e0 + 80, "s5_idle",     0, 1, 1, 0, 0);
`endif
      tick(82);

      // restart counter saturation
      rst = 1'b1;
      tick(2);
      rst = 1'b0; blk_lock = 1'b1;
      for (int i = 0; i < 300; i++) begin
         n = 0;
         while (pcs_rst !== 1'b0 && n < 40) begin
            tick(1);
            n++;
         end
         if (n >= 40) begin
            chk("s6_wait_pcs", {11'b0, pcs_rst}, 12'h000);
            break;
         end
         pll_lock = 1'b0;
         tick(3);
         pll_lock = 1'b1;
         if (i == 9) push(cyc + 1, "s6_cnt10", 1, 1, 1, 0, 10);
      end
      push(cyc + 1, "s6_sat", 1, 1, 1, 0, 255);
      tick(2);

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         tick(1);
         n++;
      end
      if (sb.size() > 0) chk("sb_left", 12'(sb.size()), 12'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
